tapu_seq: RTL and testbench

Tile sequencer for one TAPU column group. Accepts one compute command, drives the array's mode, Y-tile select, partial-sum clear and output-buffer enable, and streams operand-buffer read addresses for K steps. After the stream it waits out the systolic skew and drain, then signals completion. It sits between the kernel-level instruction decoder and the chained TAPU instances, and is the only driver of their control inputs.

---
 rtl/tapu_seq_pkg.sv | 32 +++
 rtl/tapu_seq.sv | 151 +++++++++++++++
 tb/tb_tapu_seq.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tapu_seq_pkg.sv
// Shared types and constants for the TAPU tile sequencer.
// Array modes, sequencer states and the post-stream drain length.
package tapu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      STREAM,
      DRAIN,
      OUT,
      DONE
   } tapu_seq_state_e;

   localparam logic [1:0] MODE_MATMUL  = 2'b00;
   localparam logic [1:0] MODE_ILLEGAL = 2'b01;
   localparam logic [1:0] MODE_FPMUL   = 2'b10;
   localparam logic [1:0] MODE_FPADD   = 2'b11;

   localparam int unsigned ROWS_PER_TAPU = 4;

   // Matmul must wait out the row skew of every chained TAPU plus column propagation.
   function automatic int unsigned drain_len(input logic [1:0]  mode,
                                             input int unsigned num_tapu,
                                             input int unsigned cols,
                                             input int unsigned pe_lat);
      if (mode == MODE_MATMUL) begin
         return num_tapu * ROWS_PER_TAPU + cols + pe_lat;
      end
      return pe_lat;
   endfunction

endpackage

// File: rtl/tapu_seq.sv
// Tile sequencer: accepts one compute command and drives the TAPU array
// control through clear, operand stream, drain, output and completion.
module tapu_seq
   import tapu_seq_pkg::*;
#(
   parameter int unsigned NUM_TAPU = 4,
   parameter int unsigned COLS     = 16,
   parameter int unsigned PE_LAT   = 2,
   parameter int unsigned K_WIDTH  = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_mode,
   input  logic [K_WIDTH-1:0] cmd_k,
   input  logic               cmd_accum,
   input  logic               cmd_y_sel,
   output logic               rd_en,
   output logic [K_WIDTH-1:0] rd_addr,
   output logic [1:0]         mode_sel_out,
   output logic               y_sel_out,
   output logic               psu_clr_out,
   output logic               sys_buf_en_out,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int unsigned D_MM    = drain_len(MODE_MATMUL, NUM_TAPU, COLS, PE_LAT);
   localparam int unsigned D_FP    = drain_len(MODE_FPADD, NUM_TAPU, COLS, PE_LAT);
   localparam int unsigned OUT_LEN = NUM_TAPU * ROWS_PER_TAPU;
   localparam int unsigned CW_MIN  = $clog2(D_MM + 1);
   localparam int unsigned CNT_W   = (K_WIDTH > CW_MIN) ? K_WIDTH : CW_MIN;

   tapu_seq_state_e    state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [K_WIDTH-1:0] addr_q, addr_d;
   logic [K_WIDTH-1:0] k_q, k_d;
   logic [1:0]         mode_q, mode_d;
   logic               y_q, y_d;
   logic               accum_q, accum_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   drain_cnt;
   logic               cnt_last;

   assign drain_cnt = (mode_q == MODE_MATMUL) ? CNT_W'(D_MM) : CNT_W'(D_FP);
   assign cnt_last  = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         k_q     <= '0;
         mode_q  <= MODE_MATMUL;
         y_q     <= 1'b0;
         accum_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
         y_q     <= y_d;
         accum_q <= accum_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      k_d     = k_q;
      mode_d  = mode_q;
      y_d     = y_q;
      accum_d = accum_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               // An illegal mode is consumed without disturbing the array controls.
               if (cmd_mode == MODE_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  mode_d  = cmd_mode;
                  y_d     = cmd_y_sel;
                  accum_d = cmd_accum;
                  k_d     = cmd_k;
                  addr_d  = '0;
                  state_d = CLR;
               end
            end
         end
         CLR: begin
            if (k_q == '0) begin
               state_d = DRAIN;
               cnt_d   = drain_cnt;
            end else begin
               state_d = STREAM;
               cnt_d   = CNT_W'(k_q);
            end
         end
         STREAM: begin
            // Address stops on the final step so k = max never wraps it.
            if (cnt_last) begin
               state_d = DRAIN;
               cnt_d   = drain_cnt;
            end else begin
               cnt_d  = cnt_q - CNT_W'(1);
               addr_d = addr_q + K_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (cnt_last) begin
               state_d = OUT;
               cnt_d   = CNT_W'(OUT_LEN);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         OUT: begin
            if (cnt_last) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_ready      = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign rd_en          = (state_q == STREAM);
   assign rd_addr        = addr_q;
   assign psu_clr_out    = (state_q == CLR) && !accum_q;
   assign sys_buf_en_out = (state_q == OUT);
   assign done           = (state_q == DONE);
   assign err            = err_q;
   assign mode_sel_out   = mode_q;
   assign y_sel_out      = y_q;

endmodule

// File: tb/tb_tapu_seq.sv
// Self-checking bench for tapu_seq: per-cycle expected control vectors are
// queued when a command is driven and compared as the sequencer runs.
module tb_tapu_seq;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_mode;
   logic [11:0] cmd_k;
   logic        cmd_accum;
   logic        cmd_y_sel;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [1:0]  mode_sel_out;
   logic        y_sel_out;
   logic        psu_clr_out;
   logic        sys_buf_en_out;
   logic        busy;
   logic        done;
   logic        err;

   tapu_seq #(
      .NUM_TAPU (4),
      .COLS     (16),
      .PE_LAT   (2),
      .K_WIDTH  (12)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_mode       (cmd_mode),
      .cmd_k          (cmd_k),
      .cmd_accum      (cmd_accum),
      .cmd_y_sel      (cmd_y_sel),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .mode_sel_out   (mode_sel_out),
      .y_sel_out      (y_sel_out),
      .psu_clr_out    (psu_clr_out),
      .sys_buf_en_out (sys_buf_en_out),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       rd_en;
      logic       clr;
      logic       buf_en;
      logic       done;
      logic       err;
      logic [1:0] mode;
      logic       y;
   } ctl_t;

   typedef struct {
      ctl_t        c;
      logic [11:0] addr;
      int          cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] exp_mode = 2'b00;
   logic       exp_y = 1'b0;

   function automatic ctl_t obs();
      return ctl_t'({cmd_ready, busy, rd_en, psu_clr_out, sys_buf_en_out,
                     done, err, mode_sel_out, y_sel_out});
   endfunction

   // Expected control per cycle after accept; ncyc <= 0 means up to one IDLE cycle after DONE.
   function automatic void push_cmd(input logic [1:0] m, input int k, input bit acc,
                                    input bit y, input int ncyc);
      int   d;
      int   td;
      int   n;
      exp_t e;
      d  = (m == 2'b00) ? (4 * 4 + 16 + 2) : 2;
      td = 1 + k + d + 16 + 1;
      n  = (ncyc <= 0) ? td + 1 : ncyc;
      exp_mode = m;
      exp_y    = y;
      for (int c = 1; c <= n; c++) begin
         e.cyc      = c;
         e.c.busy   = (c <= td);
         e.c.ready  = (c > td);
         e.c.rd_en  = (c >= 2) && (c <= k + 1);
         e.c.clr    = (c == 1) && !acc;
         e.c.buf_en = (c >= k + d + 2) && (c <= k + d + 16 + 1);
         e.c.done   = (c == td);
         e.c.err    = 1'b0;
         e.c.mode   = m;
         e.c.y      = y;
         e.addr     = e.c.rd_en ? 12'(c - 2) : 12'd0;
         exp_q.push_back(e);
      end
   endfunction

   function automatic void push_idle(input int n, input bit err_first);
      exp_t e;
      for (int c = 1; c <= n; c++) begin
         e.cyc = c;
         e.c   = ctl_t'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         (err_first && c == 1), exp_mode, exp_y});
         e.addr = 12'd0;
         exp_q.push_back(e);
      end
   endfunction

   task automatic drive_cmd(input logic [1:0] m, input int k, input bit acc, input bit y);
      cmd_valid = 1'b1;
      cmd_mode  = m;
      cmd_k     = 12'(k);
      cmd_accum = acc;
      cmd_y_sel = y;
   endtask

   task automatic test_reset();
      ctl_t o;
      rst_n = 1'b0;
      drive_cmd(2'b00, 3, 0, 1);
      repeat (3) @(negedge clk);
      o = obs();
      n_cmp++;
      if (o !== ctl_t'(10'b1000000000) || rd_addr !== 12'd0) begin
         n_err++;
         $display("FAIL reset: got ctl=%b addr=%0d, want ctl=1000000000 addr=0", o, rd_addr);
      end
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      exp_mode = 2'b00;
      exp_y = 1'b0;
      @(negedge clk);
      o = obs();
      n_cmp++;
      if (o !== ctl_t'(10'b1000000000)) begin
         n_err++;
         $display("FAIL reset_release: got ctl=%b, want ctl=1000000000", o);
      end
      $display("reset: checked idle outputs");
   endtask

   task automatic test_matmul();
      exp_t e;
      ctl_t o;
      drive_cmd(2'b00, 8, 0, 1);
      push_cmd(2'b00, 8, 0, 1, 0);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         o = obs();
         n_cmp++;
         if (o !== e.c || (e.c.rd_en && rd_addr !== e.addr)) begin
            n_err++;
            $display("FAIL matmul cyc %0d: got ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     e.cyc, o, rd_addr, e.c, e.addr);
         end
      end
      $display("matmul k=8: done");
   endtask

   task automatic test_fpadd();
      exp_t e;
      ctl_t o;
      drive_cmd(2'b11, 4, 1, 0);
      push_cmd(2'b11, 4, 1, 0, 0);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         o = obs();
         n_cmp++;
         if (o !== e.c || (e.c.rd_en && rd_addr !== e.addr)) begin
            n_err++;
            $display("FAIL fpadd cyc %0d: got ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     e.cyc, o, rd_addr, e.c, e.addr);
         end
      end
      $display("fpadd k=4 accum=1: done");
   endtask

   task automatic test_illegal();
      exp_t e;
      ctl_t o;
      drive_cmd(2'b01, 5, 0, 1);
      push_idle(4, 1);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         o = obs();
         n_cmp++;
         if (o !== e.c) begin
            n_err++;
            $display("FAIL illegal cyc %0d: got ctl=%b, want ctl=%b", e.cyc, o, e.c);
         end
      end
      $display("illegal mode: done");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      ctl_t o;
      int   i;
      drive_cmd(2'b00, 8, 0, 1);
      push_cmd(2'b00, 8, 0, 1, 60);
      push_idle(1, 0);
      push_cmd(2'b10, 3, 0, 0, 0);
      i = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         o = obs();
         n_cmp++;
         if (o !== e.c || (e.c.rd_en && rd_addr !== e.addr)) begin
            n_err++;
            $display("FAIL back_to_back entry %0d: got ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     i, o, rd_addr, e.c, e.addr);
         end
         if (i == 0) drive_cmd(2'b10, 3, 0, 0);
         if (i == 61) cmd_valid = 1'b0;
         i++;
      end
      $display("back_to_back: done");
   endtask

   task automatic test_k0();
      exp_t e;
      ctl_t o;
      drive_cmd(2'b00, 0, 0, 0);
      push_cmd(2'b00, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         o = obs();
         n_cmp++;
         if (o !== e.c) begin
            n_err++;
            $display("FAIL k0 cyc %0d: got ctl=%b, want ctl=%b", e.cyc, o, e.c);
         end
      end
      $display("matmul k=0: done");
   endtask

   task automatic test_kmax();
      exp_t e;
      ctl_t o;
      drive_cmd(2'b10, 4095, 0, 1);
      push_cmd(2'b10, 4095, 0, 1, 0);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         o = obs();
         n_cmp++;
         if (o !== e.c || (e.c.rd_en && rd_addr !== e.addr)) begin
            n_err++;
            $display("FAIL kmax cyc %0d: got ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     e.cyc, o, rd_addr, e.c, e.addr);
         end
      end
      $display("fpmul k=4095: done");
   endtask

   task automatic test_reset_mid();
      exp_t e;
      ctl_t o;
      int   i;
      drive_cmd(2'b00, 8, 0, 1);
      push_cmd(2'b00, 8, 0, 1, 5);
      exp_mode = 2'b00;
      exp_y    = 1'b0;
      push_idle(1, 0);
      push_cmd(2'b11, 2, 0, 1, 0);
      i = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         o = obs();
         n_cmp++;
         if (o !== e.c || (e.c.rd_en && rd_addr !== e.addr) || (i == 5 && rd_addr !== 12'd0)) begin
            n_err++;
            $display("FAIL reset_mid entry %0d: got ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     i, o, rd_addr, e.c, e.addr);
         end
         if (i == 4) rst_n = 1'b0;
         if (i == 5) begin
            rst_n = 1'b1;
            drive_cmd(2'b11, 2, 0, 1);
         end
         i++;
      end
      $display("reset mid-command: done");
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_mode  = 2'b00;
      cmd_k     = 12'd0;
      cmd_accum = 1'b0;
      cmd_y_sel = 1'b0;
      test_reset();
      test_matmul();
      test_fpadd();
      test_illegal();
      test_back_to_back();
      test_k0();
      test_kmax();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
